sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM read/write port of the RAM controller between three requesters: m0 = CPU/bus, m1 = disk DMA, m2 = spy/debug.
- Uses a round-robin grant.
- Each requester port uses the same level handshake as the controller port:
  - Requester holds req (read) or write until ready/done.
  - Requester then drops req/write.
- The arbiter sits between the requesters and the RAM controller's sdram_* port in the same clock domain.

Parameters:
ADDR_WIDTH, 22, word address width (matches controller sdram_addr)
DATA_WIDTH, 32, data word width
TIMEOUT, 1023, watchdog limit in clk cycles (used only with SDRAM_ARB_TIMEOUT_EN)

Ports:
clk  input  1  sole clock; all logic posedge clk
reset  input  1  synchronous, active-high reset
mN_addr  input  ADDR_WIDTH  requester N address (N=0,1,2)
mN_data_in  input  DATA_WIDTH  requester N write data
mN_data_out  output  DATA_WIDTH  read data; valid while mN_ready=1
mN_req  input  1  requester N read request (level)
mN_write  input  1  requester N write request (level)
mN_ready  output  1  read complete to requester N
mN_done  output  1  write complete to requester N
sdram_addr  output  ADDR_WIDTH  to controller
sdram_data_out  output  DATA_WIDTH  write data to controller
sdram_data_in  input  DATA_WIDTH  read data from controller
sdram_req  output  1  read request to controller
sdram_write  output  1  write request to controller
sdram_ready  input  1  controller read complete
sdram_done  input  1  controller write complete
grant  output  2  current owner (0..2); 3 = none
arb_error  output  1  sticky watchdog flag (0 when feature absent)

Behaviour:
- Reset values:
  - All outputs 0, except grant = 3.
  - State = IDLE; round-robin pointer = last owner 2, so m0 has first priority.
- States:
  - IDLE:
    - Sample requests; requester N is pending if mN_req|mN_write.
    - Pick the first pending requester after the last owner, modulo 3.
    - Register grant and the op: read if mN_req, else write (req wins if both are high).
    - Latch addr and data into the downstream registers; go to ISSUE.
    - If nothing is pending, stay in IDLE.
  - ISSUE:
    - Assert registered sdram_req or sdram_write; sdram_addr/sdram_data_out are held stable.
    - On sdram_ready (read) or sdram_done (write):
      - Capture sdram_data_in into the shared read register (reads only).
      - Set mG_ready or mG_done the next cycle; go to HOLD.
  - HOLD:
    - Keep sdram_req/sdram_write asserted.
    - Keep mG_ready/mG_done asserted while the owner holds its request.
    - When the owner drops its request (mG_req=0 for a read, mG_write=0 for a write):
      - Deassert mG_ready/mG_done and sdram_req/sdram_write the next cycle.
      - Go to DRAIN.
  - DRAIN:
    - Wait until sdram_ready=0 and sdram_done=0.
    - Then update the round-robin pointer to the owner, set grant=3 and go to IDLE.
- Latency: unloaded read, with controller responding k cycles after sdram_req rises:
  - mN_req rises at cycle 0 → sdram_req at cycle 2 → mN_ready at cycle 3+k.
- Requests arriving while busy stay pending; no request is lost or reordered within a requester.
- Ready/done is asserted only to the owner. Non-owners see ready=done=0 regardless of the controller.
- mN_data_out is driven from the shared read register for all N; consumers qualify it with mN_ready.
- A requester changing addr/data after grant has no effect; the latched values are used.
- Fairness: with all three continuously requesting, grants cycle 0,1,2,0,...; no requester waits more than 2 other transactions.
- Owner dropping its request during ISSUE (protocol violation): the transaction completes downstream, no ready/done is returned, then normal DRAIN.
- Reset mid-transaction:
  - Outputs return to reset values next cycle and state returns to IDLE.
  - The controller sees its request drop; the arbiter waits in IDLE for no extra condition.

Optional Feature:
- SDRAM_ARB_TIMEOUT_EN defined:
  - A 10-bit counter runs in ISSUE.
  - If TIMEOUT cycles elapse without sdram_ready/sdram_done:
    - Return ready (data = all ones) or done to the owner; set arb_error (sticky until reset).
    - Proceed to HOLD, then DRAIN.
  - DRAIN is also bounded by TIMEOUT; on expiry go to IDLE.
- Undefined: no counter; ISSUE/DRAIN wait indefinitely; arb_error tied 0.

Test Plan:
- Single read: m1_req=1, m1_addr=22'h000123; controller returns 32'hDEADBEEF after 3 cycles.
  - Expect sdram_addr=22'h000123, grant=1, m1_ready high with m1_data_out=32'hDEADBEEF.
  - After m1_req drops, grant=3 and sdram_req=0.
- Write: m0_write=1, m0_addr=22'h3FFFFF, data 32'h12345678.
  - Expect sdram_write=1 with the same addr/data; m0_done only after sdram_done; m1_done/m2_done stay 0.
- Round-robin: all three assert req simultaneously and each re-asserts immediately after completion.
  - Grant order 0,1,2,0,1,2 over 6 transactions.
- Simultaneous req and write on m2: performs a read first (sdram_req=1, sdram_write=0); the write is serviced on a subsequent grant.
- Reset mid-ISSUE with sdram_req=1: the cycle after reset, sdram_req=0, grant=3 and all ready/done=0; a new m0_req is then served normally.
- With SDRAM_ARB_TIMEOUT_EN, TIMEOUT=16, controller never responds to an m0 read:
  - Expect m0_ready after 16 cycles in ISSUE, m0_data_out=32'hFFFFFFFF, arb_error=1 until reset.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Level-handshake SDRAM word port: master issues req/write, slave answers ready/done.
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  req;
  logic                  write;
  logic                  ready;
  logic                  done;

  modport master (output addr, wdata, req, write, input  rdata, ready, done);
  modport slave  (input  addr, wdata, req, write, output rdata, ready, done);
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between CPU (m0), disk DMA (m1), debug (m2).
// Define SDRAM_ARB_TIMEOUT_EN to add the ISSUE/DRAIN watchdog and sticky arb_error.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  m0,
  sdram_port_arbiter_if.slave  m1,
  sdram_port_arbiter_if.slave  m2,
  sdram_port_arbiter_if.master sdram,
  output logic [1:0]           grant,
  output logic                 arb_error
);
  localparam int NSLOT = 4;  // slot 3 doubles as the "no owner" encoding and is tied off

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DRAIN} state_t;

  logic [NSLOT-1:0]                 w_req, w_wr, w_pend;
  logic [NSLOT-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NSLOT-1:0][DATA_WIDTH-1:0] w_wdata;

  assign w_req   = {1'b0, m2.req, m1.req, m0.req};
  assign w_wr    = {1'b0, m2.write, m1.write, m0.write};
  assign w_pend  = w_req | w_wr;
  assign w_addr  = {{ADDR_WIDTH{1'b0}}, m2.addr, m1.addr, m0.addr};
  assign w_wdata = {{DATA_WIDTH{1'b0}}, m2.wdata, m1.wdata, m0.wdata};

  state_t                r_state;
  logic [1:0]            r_grant, r_last;
  logic                  r_op_rd, r_sreq, r_swr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [2:0]            r_ready, r_done;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts just after the last owner, ending on the last owner itself.
  logic [1:0] w_c1, w_c2, w_sel;
  logic       w_any;
  assign w_c1 = nxt(r_last);
  assign w_c2 = nxt(w_c1);

  always_comb begin
    w_sel = r_last;
    w_any = 1'b1;
    if (w_pend[w_c1])        w_sel = w_c1;
    else if (w_pend[w_c2])   w_sel = w_c2;
    else if (w_pend[r_last]) w_sel = r_last;
    else                     w_any = 1'b0;
  end

  logic w_own_hold, w_resp, w_fire, w_drain_ok, w_tmo_hit;
  assign w_own_hold = r_op_rd ? w_req[r_grant] : w_wr[r_grant];
  assign w_resp     = r_op_rd ? sdram.ready : sdram.done;
  assign w_fire     = (r_sreq | r_swr) & w_resp;
  assign w_drain_ok = !sdram.ready && !sdram.done;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] r_tmo;
  logic       r_err;
  assign w_tmo_hit = (r_tmo == TMO_LAST);
  assign arb_error = r_err;

  // Counter restarts on every entry to ISSUE or DRAIN, since both are entered from non-counting states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE && !w_fire && w_tmo_hit) r_err <= 1'b1;
      if (r_state == S_ISSUE || r_state == S_DRAIN) r_tmo <= r_tmo + 10'd1;
      else                                          r_tmo <= '0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign arb_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= 2'd3;
      r_last  <= 2'd2;
      r_op_rd <= 1'b0;
      r_sreq  <= 1'b0;
      r_swr   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_op_rd <= w_req[w_sel];
            r_addr  <= w_addr[w_sel];
            r_wdata <= w_wdata[w_sel];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_sreq <= r_op_rd;
          r_swr  <= !r_op_rd;
          if (w_fire || w_tmo_hit) begin
            if (r_op_rd) r_rdata <= w_fire ? sdram.rdata : '1;
            // An owner that already let go gets no completion strobe.
            if (w_own_hold) begin
              r_ready[r_grant] <= r_op_rd;
              r_done[r_grant]  <= !r_op_rd;
            end
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!w_own_hold) begin
            r_ready <= '0;
            r_done  <= '0;
            r_sreq  <= 1'b0;
            r_swr   <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drain_ok || w_tmo_hit) begin
            r_last  <= r_grant;
            r_grant <= 2'd3;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0.rdata = r_rdata;
  assign m1.rdata = r_rdata;
  assign m2.rdata = r_rdata;
  assign m0.ready = r_ready[0];
  assign m1.ready = r_ready[1];
  assign m2.ready = r_ready[2];
  assign m0.done  = r_done[0];
  assign m1.done  = r_done[1];
  assign m2.done  = r_done[2];

  assign sdram.addr  = r_addr;
  assign sdram.wdata = r_wdata;
  assign sdram.req   = r_sreq;
  assign sdram.write = r_swr;
  assign grant       = r_grant;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small latency-programmable controller model.
module tb_sdram_port_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       arb_error;

  sdram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
  sdram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();
  sdram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m2 ();
  sdram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sd ();

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .m0(m0), .m1(m1), .m2(m2), .sdram(sd),
    .grant(grant), .arb_error(arb_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller model: answers ctl_lat cycles after req/write is first seen, holds until it drops.
  int          ctl_lat  = 3;
  logic [31:0] ctl_data = '0;
  bit          ctl_mute = 1'b0;
  int          ctl_cnt  = 0;

  initial begin
    sd.ready = 1'b0;
    sd.done  = 1'b0;
    sd.rdata = '0;
    forever begin
      @(negedge clk);
      if ((sd.req || sd.write) && !ctl_mute) begin
        ctl_cnt++;
        if (ctl_cnt > ctl_lat) begin
          sd.ready = sd.req;
          sd.done  = sd.write;
          sd.rdata = ctl_data;
        end
      end else begin
        ctl_cnt  = 0;
        sd.ready = 1'b0;
        sd.done  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int         w;
  logic [1:0] who;
  bit         saw;

  initial begin
    reset = 1'b1;
    m0.req = 0; m0.write = 0; m0.addr = '0; m0.wdata = '0;
    m1.req = 0; m1.write = 0; m1.addr = '0; m1.wdata = '0;
    m2.req = 0; m2.write = 0; m2.addr = '0; m2.wdata = '0;
    tick(3);

    // reset state
    chk("rst_grant", grant, 2'd3);
    chk("rst_sreq", sd.req, 0);
    chk("rst_swr", sd.write, 0);
    chk("rst_saddr", sd.addr, 0);
    chk("rst_sdata", sd.wdata, 0);
    chk("rst_acks", {m0.ready, m1.ready, m2.ready, m0.done, m1.done, m2.done}, 0);
    chk("rst_err", arb_error, 0);
    reset = 1'b0;
    tick();

    // single read on m1, k=3: sdram_req in cycle 2, m1_ready in cycle 6
    ctl_lat = 3; ctl_data = 32'hDEADBEEF;
    m1.addr = 22'h000123; m1.req = 1'b1;
    tick();
    chk("rd_grant", grant, 2'd1);
    chk("rd_sreq_c1", sd.req, 0);
    tick();
    chk("rd_sreq_c2", sd.req, 1);
    chk("rd_addr", sd.addr, 22'h000123);
    tick(3);
    chk("rd_rdy_c5", m1.ready, 0);
    tick();
    chk("rd_rdy_c6", m1.ready, 1);
    chk("rd_data", m1.rdata, 32'hDEADBEEF);
    chk("rd_nonowner", {m0.ready, m2.ready, m0.done, m1.done, m2.done}, 0);
    tick();
    chk("rd_rdy_hold", m1.ready, 1);
    chk("rd_sreq_hold", sd.req, 1);
    m1.req = 1'b0;
    tick();
    chk("rd_rdy_drop", m1.ready, 0);
    chk("rd_sreq_drop", sd.req, 0);
    tick();
    chk("rd_idle_grant", grant, 2'd3);

    // write on m0; addr/data changes after grant must not leak through
    ctl_lat = 2;
    m0.addr = 22'h3FFFFF; m0.wdata = 32'h12345678; m0.write = 1'b1;
    tick();
    chk("wr_grant", grant, 2'd0);
    m0.addr = '0; m0.wdata = '0;
    tick();
    chk("wr_swr", sd.write, 1);
    chk("wr_sreq", sd.req, 0);
    chk("wr_addr", sd.addr, 22'h3FFFFF);
    chk("wr_data", sd.wdata, 32'h12345678);
    tick(2);
    chk("wr_done_early", m0.done, 0);
    tick();
    chk("wr_done", m0.done, 1);
    chk("wr_nonowner", {m1.done, m2.done, m0.ready}, 0);
    m0.write = 1'b0;
    tick();
    chk("wr_swr_drop", sd.write, 0);
    chk("wr_done_drop", m0.done, 0);
    tick();
    chk("wr_idle_grant", grant, 2'd3);

    // round robin from reset: 0,1,2,0,1,2
    reset = 1'b1; tick(); reset = 1'b0;
    ctl_lat = 1;
    m0.addr = 22'h10; m1.addr = 22'h11; m2.addr = 22'h12;
    m0.req = 1'b1; m1.req = 1'b1; m2.req = 1'b1;
    for (int t = 0; t < 6; t++) begin
      ctl_data = 32'hA0000000 + t;
      for (w = 0; w < 100 && !(m0.ready | m1.ready | m2.ready); w++) tick();
      chk("rr_seen", m0.ready | m1.ready | m2.ready, 1);
      who = m1.ready ? 2'd1 : (m2.ready ? 2'd2 : 2'd0);
      chk("rr_order", who, t % 3);
      chk("rr_grant", grant, t % 3);
      chk("rr_onehot", {m0.ready, m1.ready, m2.ready}, 3'b100 >> (t % 3));
      chk("rr_data", m0.rdata, 32'hA0000000 + t);
      case (who)
        2'd0:    m0.req = 1'b0;
        2'd1:    m1.req = 1'b0;
        default: m2.req = 1'b0;
      endcase
      tick();
      case (who)
        2'd0:    m0.req = 1'b1;
        2'd1:    m1.req = 1'b1;
        default: m2.req = 1'b1;
      endcase
      tick();
    end

    // owner drops during ISSUE: transaction finishes downstream, no ready returned
    m1.req = 1'b0; m2.req = 1'b0;
    for (w = 0; w < 100 && !sd.req; w++) tick();
    chk("viol_issued", sd.req, 1);
    chk("viol_grant", grant, 2'd0);
    m0.req = 1'b0;
    saw = 1'b0;
    for (w = 0; w < 100 && grant != 2'd3; w++) begin
      if (m0.ready) saw = 1'b1;
      tick();
    end
    chk("viol_no_ready", saw, 0);
    chk("viol_idle", grant, 2'd3);

    // req and write together on m2: read first, write afterwards
    ctl_data = 32'h5A5A5A5A;
    m2.addr = 22'h02AAAA; m2.wdata = 32'hCAFEF00D; m2.req = 1'b1; m2.write = 1'b1;
    for (w = 0; w < 100 && !(sd.req || sd.write); w++) tick();
    chk("both_rd_req", sd.req, 1);
    chk("both_rd_wr", sd.write, 0);
    chk("both_rd_grant", grant, 2'd2);
    for (w = 0; w < 100 && !m2.ready; w++) tick();
    chk("both_rd_ready", m2.ready, 1);
    chk("both_rd_data", m2.rdata, 32'h5A5A5A5A);
    m2.req = 1'b0;
    for (w = 0; w < 100 && !sd.write; w++) tick();
    chk("both_wr_write", sd.write, 1);
    chk("both_wr_req", sd.req, 0);
    chk("both_wr_grant", grant, 2'd2);
    chk("both_wr_data", sd.wdata, 32'hCAFEF00D);
    for (w = 0; w < 100 && !m2.done; w++) tick();
    chk("both_wr_done", m2.done, 1);
    m2.write = 1'b0;
    for (w = 0; w < 100 && grant != 2'd3; w++) tick();
    chk("both_idle", grant, 2'd3);

    // reset while ISSUE holds sdram_req against a silent controller
    ctl_mute = 1'b1;
    m0.addr = 22'h55; m0.req = 1'b1;
    for (w = 0; w < 100 && !sd.req; w++) tick();
    chk("rmid_issued", sd.req, 1);
`ifndef SDRAM_ARB_TIMEOUT_EN
    tick(40);
    chk("mute_no_ready", m0.ready, 0);
    chk("mute_grant", grant, 2'd0);
    chk("mute_err", arb_error, 0);
`endif
    reset = 1'b1; m0.req = 1'b0;
    tick();
    chk("rmid_sreq", sd.req, 0);
    chk("rmid_grant", grant, 2'd3);
    chk("rmid_acks", {m0.ready, m1.ready, m2.ready, m0.done, m1.done, m2.done}, 0);
    reset = 1'b0; ctl_mute = 1'b0; ctl_data = 32'h0BADF00D;
    m0.addr = 22'h77; m0.req = 1'b1;
    for (w = 0; w < 100 && !m0.ready; w++) tick();
    chk("rmid_new_ready", m0.ready, 1);
    chk("rmid_new_data", m0.rdata, 32'h0BADF00D);
    chk("rmid_new_addr", sd.addr, 22'h77);
    m0.req = 1'b0;
    for (w = 0; w < 100 && grant != 2'd3; w++) tick();
    chk("rmid_idle", grant, 2'd3);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // watchdog: TIMEOUT=16, controller silent on an m0 read
    ctl_mute = 1'b1;
    m0.addr = 22'h99; m0.req = 1'b1;
    tick(16);
    chk("tmo_before", m0.ready, 0);
    chk("tmo_err_before", arb_error, 0);
    tick();
    chk("tmo_ready", m0.ready, 1);
    chk("tmo_data", m0.rdata, 32'hFFFFFFFF);
    chk("tmo_err", arb_error, 1);
    m0.req = 1'b0;
    for (w = 0; w < 100 && grant != 2'd3; w++) tick();
    chk("tmo_idle", grant, 2'd3);
    chk("tmo_err_sticky", arb_error, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("tmo_err_clr", arb_error, 0);
    ctl_mute = 1'b0;
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
